serial_pattern_scan_ctrl: RTL and testbench

- Controller that sequences the team's overlapping Moore "1011" serial pattern detector.
- Accepts W-bit words over a valid/ready handshake and serializes each word MSB-first, one bit per cycle, into the detector.
- Counts detections with a saturating counter and raises a sticky interrupt when the count reaches a programmable threshold.
- Sits between a parallel bus producer and the serial detection datapath; detector state carries across words, so the bit stream is contiguous.

---
 rtl/serial_pattern_scan_ctrl_pkg.sv | 37 +++
 rtl/seq_1011_stepper.sv | 33 +++
 rtl/serial_pattern_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_serial_pattern_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_scan_ctrl_pkg.sv
// Shared types for the serial "1011" pattern scan controller.
// Holds the detector state encodings, the controller FSM encodings,
// the pattern length and the detector next-state helper.
package serial_pattern_scan_ctrl_pkg;

  localparam int PATTERN_LEN = 4;

  // Detector states are named after the suffix of the pattern seen so far.
  typedef enum logic [2:0] {
    DET_S0    = 3'd0,
    DET_S1    = 3'd1,
    DET_S10   = 3'd2,
    DET_S101  = 3'd3,
    DET_S1011 = 3'd4
  } det_state_t;

  typedef enum logic {
    CTRL_IDLE  = 1'b0,
    CTRL_SHIFT = 1'b1
  } ctrl_state_t;

  // Overlapping Moore transition table. Any encoding outside the five
  // legal states falls back to S0 so a corrupted state self-recovers.
  function automatic det_state_t det_next(input logic [2:0] cur, input logic b);
    det_state_t nxt;
    case (cur)
      DET_S0:    nxt = b ? DET_S1    : DET_S0;
      DET_S1:    nxt = b ? DET_S1    : DET_S10;
      DET_S10:   nxt = b ? DET_S101  : DET_S0;
      DET_S101:  nxt = b ? DET_S1011 : DET_S10;
      DET_S1011: nxt = b ? DET_S1    : DET_S10;
      default:   nxt = DET_S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_1011_stepper.sv
// Overlapping Moore "1011" detector that advances only when stepped.
// Ports: clock/reset_n, step + bit_in advance the state, sync_clr forces S0;
//        state is the current detector state, enter_match flags a step into S1011.
module seq_1011_stepper
  import serial_pattern_scan_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       step,
  input  logic       bit_in,
  input  logic       sync_clr,
  output logic [2:0] state,
  output logic       enter_match
);

  logic [2:0] r_state;
  logic [2:0] w_next;

  assign w_next      = det_next(r_state, bit_in);
  assign enter_match = step & (w_next == DET_S1011);
  assign state       = r_state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= DET_S0;
    end else if (sync_clr) begin
      r_state <= DET_S0;
    end else if (step) begin
      r_state <= w_next;
    end
  end

endmodule

// File: rtl/serial_pattern_scan_ctrl.sv
// Serializes W-bit words MSB-first into the "1011" detector, counts matches
// with a saturating counter and raises a sticky irq at a programmable threshold.
// Ports: valid/ready word input, clear/irq_clear/thresh control,
//        busy/bit_out serial view, match_pulse/match_count/irq results.
module serial_pattern_scan_ctrl
  import serial_pattern_scan_ctrl_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          clear,
  input  logic [CW-1:0] thresh,
  input  logic          irq_clear,
  output logic          busy,
  output logic          bit_out,
  output logic          match_pulse,
  output logic [CW-1:0] match_count,
  output logic          irq
);

  localparam int CNTW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(W - 1);
  localparam logic [CW-1:0]   CNT_MAX  = '1;

  ctrl_state_t     r_state;
  ctrl_state_t     w_state_next;
  logic [W-1:0]    r_shift;
  logic [CNTW-1:0] r_bit_cnt;
  logic [CW-1:0]   r_match_count;
  logic            r_irq;
  logic            r_last_step;

  logic            w_load;
  logic            w_step;
  logic [2:0]      w_det_state;
  logic            w_enter_match;
  logic [CW-1:0]   w_count_inc;
  logic            w_irq_set;

  // ---------------------------------------------------------------
  // Controller FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CTRL_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------
  // Controller FSM: next state and handshake/serial outputs
  // ---------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    w_step       = 1'b0;
    bit_out      = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      CTRL_IDLE: begin
        in_ready = ~clear;
        if (in_valid && !clear) begin
          w_load       = 1'b1;
          w_state_next = CTRL_SHIFT;
        end
      end
      CTRL_SHIFT: begin
        busy    = 1'b1;
        w_step  = 1'b1;
        bit_out = r_shift[W-1];
        if (r_bit_cnt == LAST_BIT) begin
          w_state_next = CTRL_IDLE;
        end
      end
      default: w_state_next = CTRL_IDLE;
    endcase
    // A clear abandons any word in flight and blocks a transfer this cycle.
    if (clear) begin
      w_state_next = CTRL_IDLE;
    end
  end

  // ---------------------------------------------------------------
  // Shift register and bit counter
  // ---------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (clear) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_shift   <= in_data;
      r_bit_cnt <= '0;
    end else if (w_step) begin
      r_shift   <= {r_shift[W-2:0], 1'b0};
      r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CNTW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Detector: state persists across words so the stream is contiguous
  // ---------------------------------------------------------------
  seq_1011_stepper u_stepper (
    .clock       (clock),
    .reset_n     (reset_n),
    .step        (w_step),
    .bit_in      (bit_out),
    .sync_clr    (clear),
    .state       (w_det_state),
    .enter_match (w_enter_match)
  );

  // ---------------------------------------------------------------
  // Match counter and sticky irq
  // ---------------------------------------------------------------
  assign w_count_inc = (r_match_count == CNT_MAX) ? r_match_count
                                                  : r_match_count + CW'(1);
  assign w_irq_set   = w_enter_match && (thresh != '0) && (w_count_inc == thresh);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_match_count <= '0;
      r_irq         <= 1'b0;
      r_last_step   <= 1'b0;
    end else if (clear) begin
      r_match_count <= '0;
      r_irq         <= 1'b0;
      r_last_step   <= 1'b0;
    end else begin
      if (w_enter_match) begin
        r_match_count <= w_count_inc;
      end
      // Set has priority over a same-cycle irq_clear.
      if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (irq_clear) begin
        r_irq <= 1'b0;
      end
      r_last_step <= w_step;
    end
  end

  // The detector is in S1011 only right after a step into it; qualifying with
  // the previous cycle's step keeps a parked S1011 from pulsing again. Both
  // terms are flops, so the pulse is glitch-free and lasts exactly one cycle.
  assign match_pulse = (w_det_state == DET_S1011) && r_last_step;
  assign match_count = r_match_count;
  assign irq         = r_irq;

endmodule

// File: tb/tb_serial_pattern_scan_ctrl.sv
module tb_serial_pattern_scan_ctrl;
  import serial_pattern_scan_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          clear;
  logic [CW-1:0] thresh;
  logic          irq_clear;
  logic          busy;
  logic          bit_out;
  logic          match_pulse;
  logic [CW-1:0] match_count;
  logic          irq;

  always #5 clock = ~clock;

  serial_pattern_scan_ctrl #(.W(W), .CW(CW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .clear       (clear),
    .thresh      (thresh),
    .irq_clear   (irq_clear),
    .busy        (busy),
    .bit_out     (bit_out),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .irq         (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a word in flight plus the window of the last
  // PATTERN_LEN serial bits; a match is simply "window == 1011".
  bit                   m_active;
  logic [W-1:0]         m_word;
  int                   m_idx;
  logic [PATTERN_LEN-1:0] m_hist;
  int                   m_count;
  bit                   m_irq;
  bit                   m_pulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_word   = '0;
    m_idx    = 0;
    m_hist   = '0;
    m_count  = 0;
    m_irq    = 1'b0;
    m_pulse  = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check every output
  // against the model, then advance the model across the coming rising edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic c, input logic ic);
    logic b;
    logic was_active;
    logic set;
    @(negedge clock);
    in_valid  = v;
    in_data   = d;
    clear     = c;
    irq_clear = ic;
    #1;
    check("in_ready",    in_ready,    !m_active && !c);
    check("busy",        busy,        m_active);
    check("bit_out",     bit_out,     m_active ? m_word[W-1-m_idx] : 1'b0);
    check("match_pulse", match_pulse, m_pulse);
    check("match_count", match_count, m_count);
    check("irq",         irq,         m_irq);
    if (c) begin
      m_active = 1'b0;
      m_idx    = 0;
      m_hist   = '0;
      m_count  = 0;
      m_irq    = 1'b0;
      m_pulse  = 1'b0;
    end else begin
      was_active = m_active;
      m_pulse    = 1'b0;
      set        = 1'b0;
      if (m_active) begin
        b      = m_word[W-1-m_idx];
        m_hist = {m_hist[PATTERN_LEN-2:0], b};
        m_idx++;
        if (m_hist == 4'b1011) begin
          m_pulse = 1'b1;
          if (m_count < CNT_MAX) m_count++;
          if (thresh != 0 && m_count == int'(thresh)) set = 1'b1;
        end
        if (m_idx == W) m_active = 1'b0;
      end
      if (set) m_irq = 1'b1;
      else if (ic) m_irq = 1'b0;
      if (!was_active && v) begin
        m_active = 1'b1;
        m_word   = d;
        m_idx    = 0;
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [W-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
    repeat (W) idle();
  endtask

  task automatic do_clear();
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    irq_clear = 1'b0;
    thresh    = '0;
    model_reset();
    #12;
    check("rst_busy",        busy,        0);
    check("rst_bit_out",     bit_out,     0);
    check("rst_match_pulse", match_pulse, 0);
    check("rst_match_count", match_count, 0);
    check("rst_irq",         irq,         0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single match, irq disabled by thresh=0
    send(8'hB0);
    idle();
    check("b0_count", match_count, 1);
    check("b0_irq",   irq,         0);
    do_clear();

    // Two overlapping matches inside one word
    send(8'hDB);
    idle();
    check("db_count", match_count, 2);
    do_clear();

    // Pattern spanning a word boundary
    send(8'h01);
    send(8'h60);
    idle();
    check("xword_count", match_count, 1);
    do_clear();

    // Threshold irq, sticky, then cleared
    thresh = 8'd3;
    send(8'hDB);
    send(8'hB0);
    idle();
    check("thr_irq_set", irq,         1);
    check("thr_count",   match_count, 3);
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle();
    check("thr_irq_clr",   irq,         0);
    check("thr_count_hold", match_count, 3);
    thresh = '0;
    do_clear();

    // Clear in the third shift cycle with in_valid held high
    cycle(1'b1, 8'hDB, 1'b0, 1'b0);
    idle();
    idle();
    cycle(1'b1, 8'hB0, 1'b1, 1'b0);
    cycle(1'b1, 8'hB0, 1'b0, 1'b0);
    repeat (W) idle();
    idle();
    check("clr_restart_count", match_count, 1);
    do_clear();

    // Randomized traffic with occasional clears, irq clears and threshold moves
    thresh = CW'($urandom_range(1, 6));
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 99) == 0) thresh = CW'($urandom_range(0, 8));
      cycle(($urandom_range(0, 3) != 0),
            W'($urandom),
            ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 19) == 0));
    end
    do_clear();

    // Saturation: 0xDB repeated yields two matches per word
    thresh = 8'd200;
    for (int i = 0; i < 130; i++) send(8'hDB);
    idle();
    check("sat_count", match_count, CNT_MAX);
    check("sat_irq",   irq,         1);
    send(8'hB0);
    check("sat_hold",  match_count, CNT_MAX);
    do_clear();
    thresh = '0;

    // Asynchronous reset in the middle of a word
    cycle(1'b1, 8'hDB, 1'b0, 1'b0);
    idle();
    idle();
    idle();
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy",        busy,        0);
    check("arst_bit_out",     bit_out,     0);
    check("arst_match_pulse", match_pulse, 0);
    check("arst_match_count", match_count, 0);
    check("arst_irq",         irq,         0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    send(8'hB0);
    idle();
    check("post_arst_count", match_count, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
